park_cmd_tx: RTL and testbench

Command transmitter for the parking-garage controller. It debounces the four operator buttons (park, fetch A, fetch B, fetch C) and checks each request against the current slot occupancy flags. It then issues the 2-bit command (00 park, 01 fetch A, 10 fetch B, 11 fetch C) on `park_or_drive`, framed by a clean strobe that drives the command receiver's `clk_receive` input. Setup and hold margins around the strobe keep the command stable at the receiver's sampling edge.

---
 rtl/park_cmd_tx.sv | 179 +++++++++++++++++
 tb/tb_park_cmd_tx.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/park_cmd_tx.sv
// Parking-garage command transmitter: debounces four operator buttons, validates
// requests against slot occupancy and frames the 2-bit command with a setup/strobe/hold strobe.
module park_cmd_tx #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned SETUP_CYCLES    = 2,
  parameter int unsigned STROBE_CYCLES   = 4,
  parameter int unsigned HOLD_CYCLES     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_park,
  input  logic       btn_a,
  input  logic       btn_b,
  input  logic       btn_c,
  input  logic       A_full,
  input  logic       B_full,
  input  logic       C_full,
  output logic [1:0] park_or_drive,
  output logic       cmd_strobe,
  output logic       busy,
  output logic       reject
);

  localparam int unsigned NB   = 4;
  localparam int unsigned DBW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned DBW1 = DBW + 1;
  localparam int unsigned MAX_SS = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int unsigned MAX_P  = (MAX_SS > HOLD_CYCLES) ? MAX_SS : HOLD_CYCLES;
  localparam int unsigned PW     = $clog2(MAX_P + 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_e;

  logic [NB-1:0]          btn_raw;
  logic [NB-1:0]          sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NB-1:0]          db_q, db_d;
  logic [NB-1:0][DBW-1:0] db_cnt_q, db_cnt_d;
  logic [NB-1:0]          evt_q, evt_d;
  state_e                 state_q, state_d;
  logic [PW-1:0]          setup_cnt_q, setup_cnt_d;
  logic [PW-1:0]          strobe_cnt_q, strobe_cnt_d;
  logic [PW-1:0]          hold_cnt_q, hold_cnt_d;
  logic [1:0]             pod_q, pod_d;
  logic                   strobe_q, strobe_d;
  logic                   busy_q, busy_d;
  logic                   reject_q, reject_d;
  logic [1:0]             cmd;
  logic                   cmd_ok;

  assign btn_raw = {btn_c, btn_b, btn_a, btn_park};

  // Synchronizers, per-button debouncers and press-edge detection
  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    db_d     = db_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < NB; i++) begin
      if (sync2_q[i] == db_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (({1'b0, db_cnt_q[i]} + DBW1'(1)) >= DBW1'(DEBOUNCE_CYCLES - 1)) begin
        db_d[i]     = ~db_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
      end
    end
    evt_d = db_d & ~db_q;
  end

  // Request arbitration (park > A > B > C) and validation against occupancy
  always_comb begin
    cmd    = 2'b00;
    cmd_ok = 1'b0;
    if (evt_q[0]) begin
      cmd    = 2'b00;
      cmd_ok = ~(A_full & B_full & C_full);
    end else if (evt_q[1]) begin
      cmd    = 2'b01;
      cmd_ok = A_full;
    end else if (evt_q[2]) begin
      cmd    = 2'b10;
      cmd_ok = B_full;
    end else if (evt_q[3]) begin
      cmd    = 2'b11;
      cmd_ok = C_full;
    end
  end

  // Transfer sequencer
  always_comb begin
    state_d      = state_q;
    setup_cnt_d  = setup_cnt_q;
    strobe_cnt_d = strobe_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    pod_d        = pod_q;
    strobe_d     = strobe_q;
    busy_d       = busy_q;
    reject_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (evt_q != '0) begin
          if (cmd_ok) begin
            pod_d       = cmd;
            busy_d      = 1'b1;
            setup_cnt_d = PW'(SETUP_CYCLES - 1);
            state_d     = SETUP;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      SETUP: begin
        if (setup_cnt_q == '0) begin
          strobe_d     = 1'b1;
          strobe_cnt_d = PW'(STROBE_CYCLES - 1);
          state_d      = STROBE;
        end else begin
          setup_cnt_d = setup_cnt_q - PW'(1);
        end
      end
      STROBE: begin
        if (strobe_cnt_q == '0) begin
          strobe_d   = 1'b0;
          hold_cnt_d = PW'(HOLD_CYCLES - 1);
          state_d    = HOLD;
        end else begin
          strobe_cnt_d = strobe_cnt_q - PW'(1);
        end
      end
      HOLD: begin
        if (hold_cnt_q == '0) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      db_q         <= '0;
      db_cnt_q     <= '0;
      evt_q        <= '0;
      state_q      <= IDLE;
      setup_cnt_q  <= '0;
      strobe_cnt_q <= '0;
      hold_cnt_q   <= '0;
      pod_q        <= 2'b00;
      strobe_q     <= 1'b0;
      busy_q       <= 1'b0;
      reject_q     <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      db_q         <= db_d;
      db_cnt_q     <= db_cnt_d;
      evt_q        <= evt_d;
      state_q      <= state_d;
      setup_cnt_q  <= setup_cnt_d;
      strobe_cnt_q <= strobe_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      pod_q        <= pod_d;
      strobe_q     <= strobe_d;
      busy_q       <= busy_d;
      reject_q     <= reject_d;
    end
  end

  assign park_or_drive = pod_q;
  assign cmd_strobe    = strobe_q;
  assign busy          = busy_q;
  assign reject        = reject_q;

endmodule

// File: tb/tb_park_cmd_tx.sv
// Bench for park_cmd_tx: directed timing checks, a request table, multi-cycle corner
// sequences and random traffic compared every cycle against an event-time reference model.
module tb_park_cmd_tx;

  localparam int DEB = 16;
  localparam int SET = 2;
  localparam int STB = 4;
  localparam int HLD = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] btn = 4'b0000;   // {c, b, a, park}
  logic [2:0] full = 3'b000;   // {C, B, A}
  logic [1:0] park_or_drive;
  logic       cmd_strobe;
  logic       busy;
  logic       reject;

  int total = 0;
  int bad   = 0;

  park_cmd_tx #(
    .DEBOUNCE_CYCLES(DEB),
    .SETUP_CYCLES   (SET),
    .STROBE_CYCLES  (STB),
    .HOLD_CYCLES    (HLD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_park     (btn[0]),
    .btn_a        (btn[1]),
    .btn_b        (btn[2]),
    .btn_c        (btn[3]),
    .A_full       (full[0]),
    .B_full       (full[1]),
    .C_full       (full[2]),
    .park_or_drive(park_or_drive),
    .cmd_strobe   (cmd_strobe),
    .busy         (busy),
    .reject       (reject)
  );

  always #5 clk = ~clk;

  task check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: button levels per edge, transfer windows from the accepted-request edge
  int         cyc = 0;
  logic [3:0] m_sync1 = '0, m_s = '0, m_db = '0, m_evt = '0;
  int         m_run[4];
  int         m_start = -1000;
  logic [1:0] exp_pod = 2'b00;
  logic       exp_busy = 1'b0, exp_strobe = 1'b0, exp_reject = 1'b0;
  bit         chk_en = 1'b0;

  task model_step();
    logic [3:0] nev;
    logic [1:0] c;
    logic       ok;
    cyc++;
    if (rst) begin
      m_sync1 = '0; m_s = '0; m_db = '0; m_evt = '0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      m_start = -1000;
      exp_pod = 2'b00; exp_busy = 1'b0; exp_strobe = 1'b0; exp_reject = 1'b0;
    end else begin
      exp_reject = 1'b0;
      if (!exp_busy && m_evt != 4'b0000) begin
        if (m_evt[0])      begin c = 2'd0; ok = (full != 3'b111); end
        else if (m_evt[1]) begin c = 2'd1; ok = full[0]; end
        else if (m_evt[2]) begin c = 2'd2; ok = full[1]; end
        else               begin c = 2'd3; ok = full[2]; end
        if (ok) begin
          m_start = cyc;
          exp_pod = c;
        end else begin
          exp_reject = 1'b1;
        end
      end
      exp_busy   = (cyc >= m_start) && (cyc < m_start + SET + STB + HLD);
      exp_strobe = (cyc >= m_start + SET) && (cyc < m_start + SET + STB);
      nev = 4'b0000;
      for (int i = 0; i < 4; i++) begin
        if (m_s[i] != m_db[i]) begin
          m_run[i]++;
          if (m_run[i] >= DEB - 1) begin
            m_db[i]  = ~m_db[i];
            m_run[i] = 0;
            nev[i]   = m_db[i];
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_s     = m_sync1;
      m_sync1 = btn;
      m_evt   = nev;
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m_run[i] = 0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      total++;
      if ({park_or_drive, cmd_strobe, busy, reject} !== {exp_pod, exp_strobe, exp_busy, exp_reject}) begin
        bad++;
        $display("FAIL model cyc=%0d got pod=%b stb=%b busy=%b rej=%b want pod=%b stb=%b busy=%b rej=%b",
                 cyc, park_or_drive, cmd_strobe, busy, reject, exp_pod, exp_strobe, exp_busy, exp_reject);
      end
    end
  end

  // Hold a button mask for len cycles, release, watch tail cycles; count strobes and rejects
  task automatic press_watch(input logic [3:0] mask, input int len, input int tail,
                             output int strobes, output int rejects);
    logic prev;
    strobes = 0;
    rejects = 0;
    prev    = cmd_strobe;
    btn     = btn | mask;
    for (int k = 0; k < len + tail; k++) begin
      @(negedge clk);
      if (cmd_strobe && !prev) strobes++;
      if (reject) rejects++;
      prev = cmd_strobe;
      if (k == len - 1) btn = btn & ~mask;
    end
  endtask

  typedef struct {
    logic [3:0] mask;
    logic [2:0] full;
    int         len;
    logic [1:0] pod;
    int         strobes;
    int         rejects;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int   ns, nr, rej_seen, wait_cnt;
    logic prev;

    vecs[0] = '{mask: 4'b0010, full: 3'b001, len: 40, pod: 2'b01, strobes: 1, rejects: 0};
    vecs[1] = '{mask: 4'b0100, full: 3'b001, len: 40, pod: 2'b01, strobes: 0, rejects: 1};
    vecs[2] = '{mask: 4'b0001, full: 3'b111, len: 40, pod: 2'b01, strobes: 0, rejects: 1};
    vecs[3] = '{mask: 4'b1000, full: 3'b100, len: 10, pod: 2'b01, strobes: 0, rejects: 0};
    vecs[4] = '{mask: 4'b1000, full: 3'b100, len: 40, pod: 2'b11, strobes: 1, rejects: 0};
    vecs[5] = '{mask: 4'b0101, full: 3'b010, len: 40, pod: 2'b00, strobes: 1, rejects: 0};

    // Exact timing of a park request held from the reset edge (edge 0)
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_pod", int'(park_or_drive), 0);
    check("rst_strobe", int'(cmd_strobe), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_reject", int'(reject), 0);
    rst    = 1'b0;
    btn[0] = 1'b1;
    rej_seen = 0;
    for (int k = 1; k <= 27; k++) begin
      @(negedge clk);
      if (reject) rej_seen++;
      if (k == 17) check("t17_busy", int'(busy), 0);
      if (k == 18) begin
        check("t18_pod", int'(park_or_drive), 0);
        check("t18_busy", int'(busy), 1);
      end
      if (k == 19) check("t19_strobe", int'(cmd_strobe), 0);
      if (k == 20) check("t20_strobe", int'(cmd_strobe), 1);
      if (k == 23) check("t23_strobe", int'(cmd_strobe), 1);
      if (k == 24) check("t24_strobe", int'(cmd_strobe), 0);
      if (k == 25) check("t25_busy", int'(busy), 1);
      if (k == 26) check("t26_busy", int'(busy), 0);
    end
    check("t_no_reject", rej_seen, 0);
    btn[0] = 1'b0;
    repeat (30) @(negedge clk);

    // Request table
    foreach (vecs[v]) begin
      full = vecs[v].full;
      press_watch(vecs[v].mask, vecs[v].len, 40, ns, nr);
      check($sformatf("vec%0d_strobes", v), ns, vecs[v].strobes);
      check($sformatf("vec%0d_rejects", v), nr, vecs[v].rejects);
      check($sformatf("vec%0d_pod", v), int'(park_or_drive), int'(vecs[v].pod));
    end

    // Fetch A pressed while a park transfer is in flight must be dropped
    full = 3'b011;
    ns   = 0;
    prev = cmd_strobe;
    btn  = 4'b0101;
    for (int k = 0; k < 90; k++) begin
      @(negedge clk);
      if (cmd_strobe && !prev) ns++;
      prev = cmd_strobe;
      if (k == 3)  btn[1] = 1'b1;
      if (k == 20) check("busy_when_a_lands", int'(busy), 1);
      if (k == 45) btn = 4'b0000;
    end
    check("busy_press_strobes", ns, 1);
    check("busy_press_pod", int'(park_or_drive), 0);

    // Reset on the second strobe-high edge of a fetch C, button held through reset
    full   = 3'b100;
    btn[3] = 1'b1;
    wait_cnt = 0;
    while (!cmd_strobe && wait_cnt < 40) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("rst_mid_strobe_seen", int'(cmd_strobe), 1);
    check("rst_mid_pod_before", int'(park_or_drive), 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_strobe", int'(cmd_strobe), 0);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_pod", int'(park_or_drive), 0);
    ns   = 0;
    prev = cmd_strobe;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (cmd_strobe && !prev) ns++;
      prev = cmd_strobe;
    end
    check("rst_mid_no_partial", ns, 0);
    for (int k = 15; k <= 34; k++) begin
      @(negedge clk);
      if (cmd_strobe && !prev) ns++;
      prev = cmd_strobe;
    end
    check("rst_mid_repress", ns, 1);
    btn[3] = 1'b0;
    repeat (40) @(negedge clk);

    // Random traffic, checked every cycle by the model
    for (int it = 0; it < 60; it++) begin
      full = 3'($urandom);
      btn  = 4'($urandom);
      repeat ($urandom_range(1, 40)) @(negedge clk);
      if ($urandom_range(0, 3) == 0) full = 3'($urandom);
      btn = 4'($urandom) & btn;
      repeat ($urandom_range(1, 30)) @(negedge clk);
      if ($urandom_range(0, 14) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      if ($urandom_range(0, 2) == 0) begin
        btn = 4'b0000;
        repeat (25) @(negedge clk);
      end
    end
    btn = 4'b0000;
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
